niu32_mem_arbiter: RTL and testbench

//  Shares the Niu32 data-memory/MMIO resource between the multicycle CPU (port 0) and a debug/loader port (port 1).

---
 rtl/niu32_mem_arbiter.sv | 117 +++++++++++
 tb/tb_niu32_mem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/niu32_mem_arbiter.sv
// niu32_mem_arbiter: round-robin arbiter sharing the Niu32 data RAM and board MMIO between the CPU (port 0) and a debug/loader port (port 1)
//
// Ports:
//   clk, reset                 single clock; synchronous active-low reset (0 = reset)
//   cpu_req/we/addr/wdata      port 0 request, held until cpu_ack
//   cpu_ack, cpu_rdata         port 0 one-cycle completion pulse and read data
//   dbg_req/we/addr/wdata      port 1 request, held until dbg_ack
//   dbg_ack, dbg_rdata         port 1 one-cycle completion pulse and read data
//   key, switch                raw board inputs, readable through MMIO
//   hex_out, ledr_out, ledg_out  MMIO output registers
//   busy                       high whenever an access is in progress
module niu32_mem_arbiter #(
    parameter int WORD_SIZE = 32,
    parameter int DMEM_WORDS = 2048,
    parameter int MEM_ADDR_BITS = 13,
    parameter int MEM_WORD_OFFSET = 2,
    parameter logic [WORD_SIZE-1:0] ADDR_HEX = 32'hFFFF0000,
    parameter logic [WORD_SIZE-1:0] ADDR_LEDR = 32'hFFFF0020,
    parameter logic [WORD_SIZE-1:0] ADDR_LEDG = 32'hFFFF0040,
    parameter logic [WORD_SIZE-1:0] ADDR_KEY = 32'hFFFF0100,
    parameter logic [WORD_SIZE-1:0] ADDR_SWITCH = 32'hFFFF0120
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [WORD_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic                 cpu_ack,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    input  logic                 dbg_req,
    input  logic                 dbg_we,
    input  logic [WORD_SIZE-1:0] dbg_addr,
    input  logic [WORD_SIZE-1:0] dbg_wdata,
    output logic                 dbg_ack,
    output logic [WORD_SIZE-1:0] dbg_rdata,
    input  logic [3:0]           key,
    input  logic [9:0]           switch,
    output logic [15:0]          hex_out,
    output logic [9:0]           ledr_out,
    output logic [7:0]           ledg_out,
    output logic                 busy
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
    state_t state, state_next;
    logic grant, last_grant, pick, any_req;
    logic lat_we;
    logic [WORD_SIZE-1:0] lat_addr, lat_wdata, rd_data;
    logic [WORD_SIZE-1:0] ram [DMEM_WORDS];
    logic [MEM_ADDR_BITS-MEM_WORD_OFFSET-1:0] ram_idx;
    logic is_hex, is_ledr, is_ledg, is_key, is_sw, is_ram;
    assign any_req = cpu_req | dbg_req;
    // On a tie the port not granted last wins; a lone request always wins.
    assign pick = (cpu_req & dbg_req) ? ~last_grant : dbg_req;
    assign ram_idx = lat_addr[MEM_ADDR_BITS-1:MEM_WORD_OFFSET];
    assign is_hex = lat_addr == ADDR_HEX;
    assign is_ledr = lat_addr == ADDR_LEDR;
    assign is_ledg = lat_addr == ADDR_LEDG;
    assign is_key = lat_addr == ADDR_KEY;
    assign is_sw = lat_addr == ADDR_SWITCH;
    assign is_ram = !(is_hex | is_ledr | is_ledg | is_key | is_sw);
    always_comb begin
        rd_data = is_hex  ? {{(WORD_SIZE-16){1'b0}}, hex_out} :
                  is_ledr ? {{(WORD_SIZE-10){1'b0}}, ledr_out} :
                  is_ledg ? {{(WORD_SIZE-8){1'b0}}, ledg_out} :
                  is_key  ? {{(WORD_SIZE-4){1'b0}}, key} :
                  is_sw   ? {{(WORD_SIZE-10){1'b0}}, switch} : ram[ram_idx];
    end
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   state_next = any_req ? S_ACCESS : S_IDLE;
            S_ACCESS: state_next = S_RESP;
            default:  state_next = S_IDLE;
        endcase
        cpu_ack = (state == S_RESP) && !grant;
        dbg_ack = (state == S_RESP) && grant;
        busy = state != S_IDLE;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            grant <= 1'b0;
            last_grant <= 1'b1;
            lat_we <= 1'b0;
            lat_addr <= '0;
            lat_wdata <= '0;
            hex_out <= '0;
            ledr_out <= '0;
            ledg_out <= '0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && any_req) begin
                grant <= pick;
                lat_we <= pick ? dbg_we : cpu_we;
                lat_addr <= pick ? dbg_addr : cpu_addr;
                lat_wdata <= pick ? dbg_wdata : cpu_wdata;
            end
            if (state == S_ACCESS && lat_we) begin
                if (is_hex) hex_out <= lat_wdata[15:0];
                if (is_ledr) ledr_out <= lat_wdata[9:0];
                if (is_ledg) ledg_out <= lat_wdata[7:0];
            end
            if (state == S_ACCESS && !lat_we) begin
                if (grant) dbg_rdata <= rd_data;
                else cpu_rdata <= rd_data;
            end
            if (state == S_RESP) last_grant <= grant;
        end
    end
    // RAM has no reset; gating with reset drops a write caught mid-access.
    always_ff @(posedge clk) begin
        if (reset && state == S_ACCESS && lat_we && is_ram) ram[ram_idx] <= lat_wdata;
    end
endmodule

// File: tb/tb_niu32_mem_arbiter.sv
// tb_niu32_mem_arbiter: scoreboard-based self-checking bench for niu32_mem_arbiter
module tb_niu32_mem_arbiter;
    localparam logic [31:0] A_HEX = 32'hFFFF0000;
    localparam logic [31:0] A_LEDR = 32'hFFFF0020;
    localparam logic [31:0] A_LEDG = 32'hFFFF0040;
    localparam logic [31:0] A_KEY = 32'hFFFF0100;
    localparam logic [31:0] A_SW = 32'hFFFF0120;

    logic clk = 0, reset = 0;
    logic cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, dbg_addr = 0, dbg_wdata = 0;
    logic cpu_ack, dbg_ack, busy;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic [3:0] key = 0;
    logic [9:0] switch = 0;
    logic [15:0] hex_out;
    logic [9:0] ledr_out;
    logic [7:0] ledg_out;

    typedef struct {
        logic port;
        logic we;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    logic [31:0] mon_rd;
    int total = 0, passed = 0;
    logic rr_last = 1'b1;

    niu32_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .key(key), .switch(switch),
        .hex_out(hex_out), .ledr_out(ledr_out), .ledg_out(ledg_out), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Completion monitor: every ack pops the oldest expected access.
    always @(negedge clk) begin
        if (reset && (cpu_ack || dbg_ack)) begin
            total++;
            if (cpu_ack && dbg_ack) begin
                $display("FAIL ack_overlap: both acks high at %0t", $time);
            end else if (sb.size() == 0) begin
                $display("FAIL unexpected_ack: cpu_ack=%0b dbg_ack=%0b with empty scoreboard", cpu_ack, dbg_ack);
            end else begin
                mon_e = sb.pop_front();
                mon_rd = dbg_ack ? dbg_rdata : cpu_rdata;
                if (dbg_ack !== mon_e.port || (!mon_e.we && mon_rd !== mon_e.data))
                    $display("FAIL scoreboard: port=%0b rdata=%h, expected port=%0b we=%0b rdata=%h",
                             dbg_ack, mon_rd, mon_e.port, mon_e.we, mon_e.data);
                else passed++;
            end
        end
    end

    task automatic set_port(input logic p, input logic rq, input logic we, input logic [31:0] a, input logic [31:0] d);
        if (p) begin
            dbg_req = rq; dbg_we = we; dbg_addr = a; dbg_wdata = d;
        end else begin
            cpu_req = rq; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        end
    endtask

    task automatic do_access(input logic p, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
        int n;
        logic got;
        exp_t e;
        @(negedge clk);
        set_port(p, 1'b1, we, a, d);
        e.port = p; e.we = we; e.data = exp_rd;
        sb.push_back(e);
        rr_last = p;
        n = 0;
        got = 0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            got = p ? dbg_ack : cpu_ack;
        end
        set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
        total++;
        if (!got || n != 2) $display("FAIL latency: port %0b addr %h ack after %0d cycles (seen=%0b), expected 2", p, a, n, got);
        else passed++;
        @(negedge clk);
        total++;
        if ((p ? dbg_ack : cpu_ack) !== 1'b0) $display("FAIL ack_pulse: port %0b ack still %0b, expected 0", p, p ? dbg_ack : cpu_ack);
        else passed++;
    endtask

    task automatic test_reset;
        reset = 0;
        repeat (2) @(negedge clk);
        total++;
        if ({hex_out, ledr_out, ledg_out, cpu_ack, dbg_ack, busy} !== 37'h0)
            $display("FAIL reset_outputs: hex=%h ledr=%h ledg=%h cpu_ack=%0b dbg_ack=%0b busy=%0b, expected all 0",
                     hex_out, ledr_out, ledg_out, cpu_ack, dbg_ack, busy);
        else passed++;
        total++;
        if (cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0)
            $display("FAIL reset_rdata: cpu_rdata=%h dbg_rdata=%h, expected 0", cpu_rdata, dbg_rdata);
        else passed++;
        reset = 1;
        rr_last = 1'b1;
    endtask

    task automatic test_rw;
        do_access(0, 1, 32'h10, 32'hDEADBEEF, 32'h0);
        do_access(0, 0, 32'h10, 32'h0, 32'hDEADBEEF);
    endtask

    task automatic test_arbitration;
        int n, n_first, n_second;
        logic first, done_c, done_d;
        exp_t e;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            first = ~rr_last;
            e.port = first; e.we = 0; e.data = 32'hDEADBEEF;
            sb.push_back(e);
            e.port = ~first;
            sb.push_back(e);
            rr_last = ~first;
            set_port(0, 1, 0, 32'h10, 32'h0);
            set_port(1, 1, 0, 32'h10, 32'h0);
            n = 0; n_first = 0; n_second = 0; done_c = 0; done_d = 0;
            while (!(done_c && done_d) && n < 20) begin
                @(negedge clk);
                n++;
                if (cpu_ack || dbg_ack) begin
                    if (n_first == 0) n_first = n;
                    else n_second = n;
                end
                if (cpu_ack) begin done_c = 1; set_port(0, 0, 0, 32'h0, 32'h0); end
                if (dbg_ack) begin done_d = 1; set_port(1, 0, 0, 32'h0, 32'h0); end
            end
            set_port(0, 0, 0, 32'h0, 32'h0);
            set_port(1, 0, 0, 32'h0, 32'h0);
            total++;
            if (n_first != 2 || n_second != 5)
                $display("FAIL arb_timing: round %0d acks at cycles %0d,%0d, expected 2,5", r, n_first, n_second);
            else passed++;
        end
    endtask

    task automatic test_mmio;
        do_access(1, 1, A_LEDR, 32'h3FF, 32'h0);
        do_access(1, 1, A_HEX, 32'h1234ABCD, 32'h0);
        total++;
        if (ledr_out !== 10'h3FF || hex_out !== 16'hABCD)
            $display("FAIL mmio_write: ledr=%h hex=%h, expected 3ff abcd", ledr_out, hex_out);
        else passed++;
        do_access(0, 1, 32'h100, 32'hCAFE0001, 32'h0);
        do_access(1, 1, A_KEY, 32'h5, 32'h0);
        total++;
        if (ledr_out !== 10'h3FF || hex_out !== 16'hABCD || ledg_out !== 8'h0)
            $display("FAIL key_write_regs: ledr=%h hex=%h ledg=%h, expected 3ff abcd 00", ledr_out, hex_out, ledg_out);
        else passed++;
        do_access(1, 0, 32'h100, 32'h0, 32'hCAFE0001);
        do_access(1, 0, A_HEX, 32'h0, 32'h0000ABCD);
        do_access(0, 1, A_LEDG, 32'hFFFFFF5A, 32'h0);
        do_access(0, 0, A_LEDG, 32'h0, 32'h0000005A);
    endtask

    task automatic test_inputs;
        key = 4'b1010;
        switch = 10'h155;
        do_access(0, 0, A_KEY, 32'h0, 32'h0000000A);
        do_access(1, 0, A_SW, 32'h0, 32'h00000155);
        do_access(0, 1, 32'h2000, 32'h7, 32'h0);
        do_access(0, 0, 32'h0, 32'h0, 32'h7);
    endtask

    task automatic test_reset_abort;
        do_access(0, 1, 32'h20, 32'h11, 32'h0);
        @(negedge clk);
        set_port(0, 1, 1, 32'h20, 32'h55);
        @(negedge clk);
        total++;
        if (busy !== 1'b1) $display("FAIL abort_busy: busy=%0b in access phase, expected 1", busy);
        else passed++;
        reset = 0;
        set_port(0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || cpu_ack !== 1'b0 || hex_out !== 16'h0)
            $display("FAIL abort_state: busy=%0b cpu_ack=%0b hex=%h, expected 0 0 0000", busy, cpu_ack, hex_out);
        else passed++;
        @(negedge clk);
        reset = 1;
        rr_last = 1'b1;
        do_access(0, 0, 32'h20, 32'h0, 32'h11);
    endtask

    initial begin
        test_reset;
        test_rw;
        test_arbitration;
        test_mmio;
        test_inputs;
        test_reset_abort;
        repeat (2) @(negedge clk);
        total++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
